// File: rtl/barrel_shift_sequencer.sv
// Registered valid/ready wrapper around a combinational 8-bit barrel shifter.
// Loads jobs onto the shifter, waits one cycle, captures and holds the result.
module barrel_shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic [WIDTH-1:0] sh_data,
    output logic [AMT_W-1:0] sh_amt,
    input  logic [WIDTH-1:0] sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AMT_W-1:0] out_amt,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic drain;
    logic capture;

    // Draining a result frees the slot in the same cycle for a new job.
    assign drain    = (state == OUT) & out_valid & out_ready;
    assign in_ready = rst_n & ((state == IDLE) | ((state == OUT) & out_ready));
    assign accept   = in_valid & in_ready;
    assign capture  = (state == EVAL);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == IDLE): begin
                if (accept)
                    state_nxt = EVAL;
            end
            (state == EVAL): begin
                state_nxt = OUT;
            end
            (state == OUT): begin
                if (drain)
                    state_nxt = accept ? EVAL : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data <= '0;
            sh_amt  <= '0;
        end else if (accept) begin
            sh_data <= in_data;
            sh_amt  <= in_amt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_amt   <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            out_data  <= sh_result;
            out_amt   <= sh_amt;
            out_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (drain)
            op_count <= op_count + 1'b1;
    end

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Directed bench for barrel_shift_sequencer with a rotate-right stub shifter.
// Counter width overridden to 4 so the wrap is reachable.
module tb_barrel_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [WIDTH-1:0] sh_data;
    logic [AMT_W-1:0] sh_amt;
    logic [WIDTH-1:0] sh_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AMT_W-1:0] out_amt;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int n_checks;
    int n_fails;

    barrel_shift_sequencer #(
        .WIDTH(WIDTH),
        .AMT_W(AMT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .sh_data  (sh_data),
        .sh_amt   (sh_amt),
        .sh_result(sh_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_amt  (out_amt),
        .busy     (busy),
        .op_count (op_count)
    );

    // Stub shifter: rotate right.
    logic [2*WIDTH-1:0] dbl;
    always_comb begin
        dbl       = {sh_data, sh_data} >> sh_amt;
        sh_result = dbl[WIDTH-1:0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b0;

        // Reset
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_sh_data", 32'(sh_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Single job
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        in_amt    = 3'd1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s_busy", 32'(busy), 32'd1);
        chk("s_eval_valid", 32'(out_valid), 32'd0);
        chk("s_sh_data", 32'(sh_data), 32'hAA);
        chk("s_sh_amt", 32'(sh_amt), 32'd1);
        tick();
        chk("s_out_valid", 32'(out_valid), 32'd1);
        chk("s_out_data", 32'(out_data), 32'h55);
        chk("s_out_amt", 32'(out_amt), 32'd1);
        tick();
        chk("s_op_count", 32'(op_count), 32'd1);
        chk("s_done_valid", 32'(out_valid), 32'd0);
        chk("s_idle", 32'(busy), 32'd0);

        // Backpressure
        in_valid  = 1'b1;
        in_data   = 8'hF0;
        in_amt    = 3'd4;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h0F);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk("bp_count_held", 32'(op_count), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rel", 32'(in_ready), 32'd1);
        tick();
        chk("bp_op_count", 32'(op_count), 32'd2);
        chk("bp_idle", 32'(busy), 32'd0);

        // Back-to-back
        in_valid = 1'b1;
        in_data  = 8'h0F;
        in_amt   = 3'd6;
        tick();
        chk("bb_eval_ready", 32'(in_ready), 32'd0);
        in_data = 8'h81;
        in_amt  = 3'd1;
        tick();
        chk("bb_data1", 32'(out_data), 32'h3C);
        chk("bb_amt1", 32'(out_amt), 32'd6);
        chk("bb_ready1", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bb_count1", 32'(op_count), 32'd3);
        chk("bb_gap_valid", 32'(out_valid), 32'd0);
        chk("bb_sh_data2", 32'(sh_data), 32'h81);
        tick();
        chk("bb_valid2", 32'(out_valid), 32'd1);
        chk("bb_data2", 32'(out_data), 32'hC0);
        chk("bb_amt2", 32'(out_amt), 32'd1);
        tick();
        chk("bb_count2", 32'(op_count), 32'd4);
        chk("bb_idle", 32'(busy), 32'd0);

        // Reset mid-job
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_amt   = 3'd3;
        tick();
        in_valid = 1'b0;
        chk("mr_in_eval", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_count", 32'(op_count), 32'd0);
        chk("mr_sh_data", 32'(sh_data), 32'd0);
        chk("mr_out_data", 32'(out_data), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        tick();
        tick();
        chk("mr_valid_late", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mr_valid_rel", 32'(out_valid), 32'd0);
        chk("mr_count_rel", 32'(op_count), 32'd0);

        // Counter wrap with identity shifts
        for (int i = 0; i < 17; i++) begin
            d = 8'((i * 13 + 7) % 256);
            in_valid = 1'b1;
            in_data  = d;
            in_amt   = 3'd0;
            tick();
            in_valid = 1'b0;
            tick();
            chk("wr_data", 32'(out_data), 32'(d));
            chk("wr_amt", 32'(out_amt), 32'd0);
            tick();
            chk("wr_count", 32'(op_count), 32'((i + 1) % 16));
        end
        chk("wr_final", 32'(op_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
